baud_cfg_ctrl: RTL and testbench

BAUD_CFG_CTRL -- requirements
Module: baud_cfg_ctrl

---
 rtl/baud_cfg_pkg.sv | 7 +
 rtl/baud_cfg_ctrl_tick.sv | 23 ++
 rtl/baud_cfg_ctrl.sv | 104 ++++++++++
 tb/tb_baud_cfg_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_cfg_pkg.sv
// baud_cfg_pkg: shared states, baud code limit and error codes for the baud configuration controller
package baud_cfg_pkg;
    typedef enum logic [2:0] {IDLE, DRAIN, APPLY, SETTLE, FINISH} state_e;
    localparam logic [2:0] BAUD_CODE_MAX = 3'd4;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
endpackage

// File: rtl/baud_cfg_ctrl_tick.sv
// bd_tick_counter: counts rising edges of the registered clk_bd baud tick while not cleared
module bd_tick_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         clk_bd,
    output logic [W-1:0] count
);
    logic         bd_q;
    logic [W-1:0] count_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            bd_q    <= 1'b0;
            count_q <= '0;
        end else begin
            bd_q    <= clk_bd;
            count_q <= clear ? '0 : count_q + W'(clk_bd & ~bd_q);
        end
    end
    assign count = count_q;
endmodule

// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: drains the UART link, applies a new baud code, waits for it to settle and reports done/err
module baud_cfg_ctrl
    import baud_cfg_pkg::*;
#(
    parameter int SETTLE_TICKS  = 2,
    parameter int DRAIN_TIMEOUT = 1048575
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    input  logic [2:0] cfg_baud,
    output logic       cfg_ready,
    input  logic       tx_busy,
    input  logic       rx_busy,
    input  logic       clk_bd,
    output logic       link_hold,
    output logic [2:0] baud,
    output logic       baud_ready,
    output logic [2:0] cur_baud,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int CW = $clog2(SETTLE_TICKS + 2);
    state_e      state_q, state_d;
    logic [2:0]  pend_q, pend_d, cur_q, cur_d;
    logic [19:0] drain_q, drain_d;
    logic        done_q, done_d, err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [CW-1:0] ticks;
    bd_tick_counter #(.W(CW)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != SETTLE),
        .clk_bd (clk_bd),
        .count  (ticks)
    );
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        drain_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            IDLE: if (cfg_valid) begin
                if (cfg_baud > BAUD_CODE_MAX) begin
                    err_d  = 1'b1;
                    code_d = ERR_ILLEGAL;
                end else if (cfg_baud == cur_q) begin
                    done_d = 1'b1;
                end else begin
                    pend_d  = cfg_baud;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (!tx_busy && !rx_busy) begin
                state_d = APPLY;
                cur_d   = pend_q;
            end else if (drain_q == 20'(DRAIN_TIMEOUT - 1)) begin
                state_d = IDLE;
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
            end else begin
                drain_d = drain_q + 20'd1;
            end
            APPLY:  state_d = SETTLE;
            SETTLE: if (ticks >= CW'(SETTLE_TICKS)) begin
                state_d = FINISH;
                done_d  = 1'b1;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cur_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end
    assign cfg_ready  = state_q == IDLE;
    assign link_hold  = state_q != IDLE;
    assign baud_ready = state_q == APPLY;
    assign baud       = cur_q;
    assign cur_baud   = cur_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;
endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// tb_baud_cfg_ctrl: directed scenario checks of baud_cfg_ctrl with DRAIN_TIMEOUT=100, SETTLE_TICKS=2
module tb_baud_cfg_ctrl;
    logic       clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, tx_busy = 1'b0, rx_busy = 1'b0, clk_bd = 1'b0;
    logic [2:0] cfg_baud = 3'd0;
    logic       cfg_ready, link_hold, baud_ready, done, err;
    logic [2:0] baud, cur_baud;
    logic [1:0] err_code;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    baud_cfg_ctrl #(.SETTLE_TICKS(2), .DRAIN_TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_baud(cfg_baud), .cfg_ready(cfg_ready),
        .tx_busy(tx_busy), .rx_busy(rx_busy), .clk_bd(clk_bd), .link_hold(link_hold), .baud(baud),
        .baud_ready(baud_ready), .cur_baud(cur_baud), .done(done), .err(err), .err_code(err_code)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({cfg_ready, link_hold, baud_ready, done, err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=10000", {cfg_ready, link_hold, baud_ready, done, err});
        end
        checks++;
        if ({baud, cur_baud, err_code} !== 8'h00) begin
            failures++;
            $display("FAIL reset_values got baud=%0d cur=%0d code=%b exp 0 0 00", baud, cur_baud, err_code);
        end
        rst = 1'b0;
    endtask

    task automatic test_same_code();
        cfg_valid = 1'b1;
        cfg_baud  = 3'd0;
        cyc();
        cfg_valid = 1'b0;
        checks++;
        if ({done, err, link_hold, baud_ready, cfg_ready} !== 5'b10001) begin
            failures++;
            $display("FAIL same_code_flags got=%b exp=10001", {done, err, link_hold, baud_ready, cfg_ready});
        end
        cyc();
        checks++;
        if ({done, link_hold, baud_ready} !== 3'b000) begin
            failures++;
            $display("FAIL same_code_after got=%b exp=000", {done, link_hold, baud_ready});
        end
    endtask

    task automatic test_apply();
        clk_bd    = 1'b0;
        cfg_valid = 1'b1;
        cfg_baud  = 3'd3;
        cyc();
        cfg_valid = 1'b0;
        cfg_baud  = 3'd7;
        checks++;
        if ({link_hold, cfg_ready, baud_ready} !== 3'b100) begin
            failures++;
            $display("FAIL apply_drain got=%b exp=100", {link_hold, cfg_ready, baud_ready});
        end
        cyc();
        checks++;
        if ({baud_ready, baud, cur_baud} !== {1'b1, 3'd3, 3'd3}) begin
            failures++;
            $display("FAIL apply_strobe got rdy=%b baud=%0d cur=%0d exp 1 3 3", baud_ready, baud, cur_baud);
        end
        cyc();
        checks++;
        if ({baud_ready, link_hold, baud} !== {2'b01, 3'd3}) begin
            failures++;
            $display("FAIL apply_settle_entry got rdy=%b hold=%b baud=%0d exp 0 1 3", baud_ready, link_hold, baud);
        end
        clk_bd = 1'b1;
        cyc();
        clk_bd = 1'b0;
        cyc();
        clk_bd = 1'b1;
        cyc();
        checks++;
        if ({done, link_hold} !== 2'b01) begin
            failures++;
            $display("FAIL apply_early_done got done=%b hold=%b exp 0 1", done, link_hold);
        end
        cyc();
        checks++;
        if ({done, err, link_hold} !== 3'b101) begin
            failures++;
            $display("FAIL apply_done got done=%b err=%b hold=%b exp 1 0 1", done, err, link_hold);
        end
        cyc();
        checks++;
        if ({done, link_hold, cfg_ready, cur_baud, baud} !== {3'b001, 3'd3, 3'd3}) begin
            failures++;
            $display("FAIL apply_idle got done=%b hold=%b rdy=%b cur=%0d exp 0 0 1 3", done, link_hold, cfg_ready, cur_baud);
        end
    endtask

    task automatic test_drain_busy();
        logic bad_rdy = 1'b0, bad_hold = 1'b0;
        clk_bd    = 1'b0;
        tx_busy   = 1'b1;
        cfg_valid = 1'b1;
        cfg_baud  = 3'd4;
        cyc();
        cfg_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (baud_ready) bad_rdy = 1'b1;
            if (!link_hold) bad_hold = 1'b1;
        end
        checks++;
        if (bad_rdy || bad_hold) begin
            failures++;
            $display("FAIL busy_hold got early_rdy=%b hold_drop=%b exp 0 0", bad_rdy, bad_hold);
        end
        tx_busy = 1'b0;
        cyc();
        checks++;
        if ({baud_ready, baud} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL busy_apply got rdy=%b baud=%0d exp 1 4", baud_ready, baud);
        end
        for (int i = 0; i < 20 && !done; i++) begin
            clk_bd = ~clk_bd;
            cyc();
        end
        checks++;
        if ({done, link_hold, cur_baud} !== {2'b11, 3'd4}) begin
            failures++;
            $display("FAIL busy_done got done=%b hold=%b cur=%0d exp 1 1 4", done, link_hold, cur_baud);
        end
        cyc();
        clk_bd = 1'b0;
    endtask

    task automatic test_illegal();
        cfg_valid = 1'b1;
        cfg_baud  = 3'd6;
        cyc();
        cfg_valid = 1'b0;
        checks++;
        if ({err, err_code, done, link_hold, cfg_ready} !== 6'b101001) begin
            failures++;
            $display("FAIL illegal_err got=%b exp=101001", {err, err_code, done, link_hold, cfg_ready});
        end
        checks++;
        if ({baud, cur_baud} !== {3'd4, 3'd4}) begin
            failures++;
            $display("FAIL illegal_baud got baud=%0d cur=%0d exp 4 4", baud, cur_baud);
        end
        cyc();
        checks++;
        if ({err, err_code} !== 3'b001) begin
            failures++;
            $display("FAIL illegal_hold got err=%b code=%b exp 0 01", err, err_code);
        end
    endtask

    task automatic test_timeout();
        logic bad = 1'b0;
        rx_busy   = 1'b1;
        cfg_valid = 1'b1;
        cfg_baud  = 3'd1;
        cyc();
        cfg_valid = 1'b0;
        for (int i = 0; i < 99; i++) begin
            cyc();
            if (!link_hold || err) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL timeout_early got early_exit=1 exp 0");
        end
        cyc();
        rx_busy = 1'b0;
        checks++;
        if ({err, err_code, link_hold, cfg_ready, done} !== 6'b110010) begin
            failures++;
            $display("FAIL timeout_err got=%b exp=110010", {err, err_code, link_hold, cfg_ready, done});
        end
        checks++;
        if ({baud, cur_baud} !== {3'd4, 3'd4}) begin
            failures++;
            $display("FAIL timeout_baud got baud=%0d cur=%0d exp 4 4", baud, cur_baud);
        end
    endtask

    task automatic test_reset_in_settle();
        rx_busy   = 1'b1;
        cfg_valid = 1'b1;
        cfg_baud  = 3'd2;
        cyc();
        cfg_valid = 1'b0;
        for (int i = 0; i < 99; i++) cyc();
        rx_busy = 1'b0;
        cyc();
        checks++;
        if ({baud_ready, err, baud} !== {2'b10, 3'd2}) begin
            failures++;
            $display("FAIL timeout_priority got rdy=%b err=%b baud=%0d exp 1 0 2", baud_ready, err, baud);
        end
        cyc();
        checks++;
        if ({link_hold, cfg_ready, baud_ready} !== 3'b100) begin
            failures++;
            $display("FAIL settle_state got hold=%b rdy=%b brdy=%b exp 1 0 0", link_hold, cfg_ready, baud_ready);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({baud, cur_baud, done, err, cfg_ready, link_hold} !== {3'd0, 3'd0, 4'b0010}) begin
            failures++;
            $display("FAIL settle_reset got baud=%0d cur=%0d done=%b err=%b rdy=%b hold=%b exp 0 0 0 0 1 0",
                     baud, cur_baud, done, err, cfg_ready, link_hold);
        end
        cyc();
        checks++;
        if ({done, err, err_code} !== 4'b0000) begin
            failures++;
            $display("FAIL settle_reset_after got done=%b err=%b code=%b exp 0 0 00", done, err, err_code);
        end
    endtask

    initial begin
        test_reset();
        test_same_code();
        test_apply();
        test_drain_busy();
        test_illegal();
        test_timeout();
        test_reset_in_settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
